// File: rtl/mac_acc_bank_pkg.sv
// rtl/mac_acc_bank_pkg.sv - shared types and the signed add/overflow helper for the accumulator bank
//
// Purpose: default widths, the output-stage state encoding and sat_add(), which
//          adds two sign-extended operands at a runtime-constant width w and
//          reports signed overflow at that width.
// Config : MAC_ACC_SAT_EN defined   -> sat_add clamps to the w-bit signed range.
//          MAC_ACC_SAT_EN undefined -> sat_add wraps modulo 2^w.
// Ports  : none (package).
package mac_acc_bank_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_ACC_W    = 22;
  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_DUMP_LEN = 8;

  // Working width of sat_add; accumulator widths up to MAX_W-1 are supported
  // so that the raw sum of two in-range operands can never overflow here.
  localparam int MAX_W = 64;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  typedef struct packed {
    logic                    ovf;
    logic signed [MAX_W-1:0] sum;
  } add_res_t;

  function automatic add_res_t sat_add(input logic signed [MAX_W-1:0] a,
                                       input logic signed [MAX_W-1:0] b,
                                       input int                      w);
    add_res_t                r;
    logic signed [MAX_W-1:0] s;
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    s     = a + b;
    hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo    = -(64'sd1 <<< (w - 1));
    r.ovf = (s > hi) || (s < lo);
`ifdef MAC_ACC_SAT_EN
    if (s > hi) begin
      r.sum = hi;
    end else if (s < lo) begin
      r.sum = lo;
    end else begin
      r.sum = s;
    end
`else
    // Keep the low w bits and re-extend their sign: modulo 2^w wrap.
    r.sum = (s <<< (MAX_W - w)) >>> (MAX_W - w);
`endif
    return r;
  endfunction

endpackage

// File: rtl/mac_acc_bank_if.sv
// rtl/mac_acc_bank_if.sv - product input and dump output handshake bundle
//
// Purpose: groups the product stream (in_*) and dump stream (out_*) plus the
//          err_ch pulse. master = product source / dump sink, slave = bank.
// Signals: in_valid, in_ready, in_ch[CH_W], in_data[DATA_W] (signed),
//          out_valid, out_ready, out_ch[CH_W], out_data[ACC_W] (signed),
//          out_ovf, err_ch.
interface mac_acc_bank_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 22,
  parameter int CH_W   = 2
) ();

  logic                     in_valid;
  logic                     in_ready;
  logic [CH_W-1:0]          in_ch;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [CH_W-1:0]          out_ch;
  logic signed [ACC_W-1:0]  out_data;
  logic                     out_ovf;
  logic                     err_ch;

  modport master (
    output in_valid, in_ch, in_data, out_ready,
    input  in_ready, out_valid, out_ch, out_data, out_ovf, err_ch
  );

  modport slave (
    input  in_valid, in_ch, in_data, out_ready,
    output in_ready, out_valid, out_ch, out_data, out_ovf, err_ch
  );

endinterface

// File: rtl/mac_acc_bank_lane.sv
// rtl/mac_acc_bank_lane.sv - one channel of the bank: accumulator, product counter, sticky overflow
//
// Purpose: integrates products for a single channel and raises a combinational
//          dump strobe on the product that completes a DUMP_LEN window; on that
//          edge the lane restarts from zero while the top captures dump_sum.
// Ports  : clk, reset (async, active-high), clear (sync flush),
//          add (a product for this lane is transferred this cycle),
//          data[DATA_W] signed product,
//          dump (this add completes the window), dump_sum[ACC_W] (sum including
//          this add), dump_ovf (sticky overflow including this add).
// Config : MAC_ACC_SAT_EN selects saturating instead of wrapping accumulation.
module mac_acc_lane
  import mac_acc_bank_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int DUMP_LEN = DEF_DUMP_LEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     add,
  input  logic signed [DATA_W-1:0] data,
  output logic                     dump,
  output logic signed [ACC_W-1:0]  dump_sum,
  output logic                     dump_ovf
);

  localparam int CNT_W = (DUMP_LEN > 1) ? $clog2(DUMP_LEN) : 1;

  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic                    ovf;
  add_res_t                r;
  logic                    unused_hi;

  always_comb begin
    r = sat_add(MAX_W'(acc), MAX_W'(data), ACC_W);
  end

  // sat_add already confines the result to ACC_W bits; the upper bits are
  // only sign copies.
  assign unused_hi = ^r.sum[MAX_W-1:ACC_W];

  assign dump     = add && (cnt == CNT_W'(DUMP_LEN - 1));
  assign dump_sum = r.sum[ACC_W-1:0];
  assign dump_ovf = ovf | r.ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (add) begin
      if (dump) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else begin
        acc <= r.sum[ACC_W-1:0];
        cnt <= cnt + 1'b1;
        ovf <= ovf | r.ovf;
      end
    end
  end

endmodule

// File: rtl/mac_acc_bank.sv
// rtl/mac_acc_bank.sv - multi-channel integrate-and-dump accumulator bank
//
// Purpose: accepts channel-tagged signed products, keeps one accumulator per
//          channel and emits each channel's sum after DUMP_LEN products through
//          a one-entry valid/ready output register.
// Ports  : clk, reset (async, active-high), clear (sync flush of lanes and
//          output stage), bus (mac_acc_bank_if.slave: in_valid/in_ready/in_ch/
//          in_data, out_valid/out_ready/out_ch/out_data/out_ovf, err_ch).
// Config : MAC_ACC_SAT_EN defined -> saturating accumulation, else wrapping.
module mac_acc_bank
  import mac_acc_bank_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int DUMP_LEN = DEF_DUMP_LEN,
  parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  mac_acc_bank_if.slave  bus
);

  out_state_t              state;
  logic [CH_W-1:0]         out_ch_r;
  logic signed [ACC_W-1:0] out_data_r;
  logic                    out_ovf_r;
  logic                    err_r;

  logic                    in_ready;
  logic                    transfer;
  logic                    ch_ok;

  logic [NUM_CH-1:0]       add;
  logic [NUM_CH-1:0]       dump;
  logic signed [ACC_W-1:0] dump_sum [NUM_CH];
  logic [NUM_CH-1:0]       dump_ovf;

  logic                    any_dump;
  logic [CH_W-1:0]         sel_ch;
  logic signed [ACC_W-1:0] sel_sum;
  logic                    sel_ovf;

  // A pending dump blocks all input unless it leaves this cycle, so a new
  // dump can only complete when the register is free or being emptied.
  assign in_ready = !clear && ((state == EMPTY) || bus.out_ready);
  assign transfer = bus.in_valid && in_ready;
  assign ch_ok    = {1'b0, bus.in_ch} < (CH_W + 1)'(NUM_CH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    assign add[i] = transfer && ch_ok && (bus.in_ch == CH_W'(i));

    mac_acc_lane #(
      .DATA_W  (DATA_W),
      .ACC_W   (ACC_W),
      .DUMP_LEN(DUMP_LEN)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear),
      .add     (add[i]),
      .data    (bus.in_data),
      .dump    (dump[i]),
      .dump_sum(dump_sum[i]),
      .dump_ovf(dump_ovf[i])
    );
  end

  // Only the addressed lane can strobe, so this is a plain one-hot mux.
  always_comb begin
    any_dump = 1'b0;
    sel_ch   = '0;
    sel_sum  = '0;
    sel_ovf  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (dump[i]) begin
        any_dump = 1'b1;
        sel_ch   = CH_W'(i);
        sel_sum  = dump_sum[i];
        sel_ovf  = dump_ovf[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      out_ch_r   <= '0;
      out_data_r <= '0;
      out_ovf_r  <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      err_r <= transfer && !ch_ok;
      if (clear) begin
        state <= EMPTY;
      end else begin
        case (state)
          EMPTY: begin
            if (any_dump) begin
              state      <= FULL;
              out_ch_r   <= sel_ch;
              out_data_r <= sel_sum;
              out_ovf_r  <= sel_ovf;
            end
          end
          FULL: begin
            if (any_dump) begin
              // Old dump is leaving on this edge; reload in place.
              out_ch_r   <= sel_ch;
              out_data_r <= sel_sum;
              out_ovf_r  <= sel_ovf;
            end else if (bus.out_ready) begin
              state <= EMPTY;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == FULL);
  assign bus.out_ch    = out_ch_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_ovf   = out_ovf_r;
  assign bus.err_ch    = err_r;

endmodule

// File: tb/tb_mac_acc_bank.sv
// tb/tb_mac_acc_bank.sv - self-checking bench for mac_acc_bank (two configurations)
module tb_mac_acc_bank;

  localparam int ND = 2;

  logic clk = 1'b0;
  logic reset;
  logic clr_a;
  logic clr_b;

  always #5 clk = ~clk;

  mac_acc_bank_if #(.DATA_W(16), .ACC_W(22), .CH_W(2)) bus_a ();
  mac_acc_bank_if #(.DATA_W(16), .ACC_W(22), .CH_W(2)) bus_b ();

  mac_acc_bank #(.DATA_W(16), .ACC_W(22), .NUM_CH(4), .DUMP_LEN(8)) dut_a (
    .clk(clk), .reset(reset), .clear(clr_a), .bus(bus_a)
  );

  mac_acc_bank #(.DATA_W(16), .ACC_W(22), .NUM_CH(3), .DUMP_LEN(72)) dut_b (
    .clk(clk), .reset(reset), .clear(clr_b), .bus(bus_b)
  );

  int checks = 0;
  int errors = 0;
  bit run_chk = 1'b0;

  // Model configuration and state, indexed by DUT number.
  int     p_acc_w [ND] = '{22, 22};
  int     p_dump  [ND] = '{8, 72};
  int     p_nch   [ND] = '{4, 3};
  longint m_acc   [ND][4];
  int     m_cnt   [ND][4];
  bit     m_ovf   [ND][4];
  bit     m_valid [ND];
  int     m_ch    [ND];
  longint m_data  [ND];
  bit     m_oovf  [ND];
  bit     m_err   [ND];

  typedef struct {
    int     ch;
    longint data;
    bit     ovf;
  } dump_t;
  dump_t log_q [ND][$];

  task automatic chk(input string nm, input int d, input logic signed [63:0] act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual %0d expected %0d at %0t", nm, d, act, exp, $time);
    end
  endtask

  task automatic model_clear_lanes(input int d);
    for (int c = 0; c < 4; c++) begin
      m_acc[d][c] = 0;
      m_cnt[d][c] = 0;
      m_ovf[d][c] = 1'b0;
    end
  endtask

  task automatic model_step(input int d, input bit clr, input bit iv, input int ich,
                            input longint idata, input bit ordy);
    bit     dumped;
    longint s, hi, lo, m;
    dumped   = 1'b0;
    m_err[d] = 1'b0;
    if (clr) begin
      model_clear_lanes(d);
      m_valid[d] = 1'b0;
      return;
    end
    if (iv && (!m_valid[d] || ordy)) begin
      if (ich >= p_nch[d]) begin
        m_err[d] = 1'b1;
      end else begin
        hi = (longint'(1) << (p_acc_w[d] - 1)) - 1;
        lo = -hi - 1;
        m  = hi - lo + 1;
        s  = m_acc[d][ich] + idata;
        if (s > hi || s < lo) m_ovf[d][ich] = 1'b1;
`ifdef MAC_ACC_SAT_EN
        if (s > hi) s = hi;
        if (s < lo) s = lo;
`else
        s = (((s - lo) % m) + m) % m + lo;
`endif
        m_acc[d][ich] = s;
        m_cnt[d][ich]++;
        if (m_cnt[d][ich] == p_dump[d]) begin
          m_valid[d] = 1'b1;
          m_ch[d]    = ich;
          m_data[d]  = s;
          m_oovf[d]  = m_ovf[d][ich];
          m_acc[d][ich] = 0;
          m_cnt[d][ich] = 0;
          m_ovf[d][ich] = 1'b0;
          dumped = 1'b1;
        end
      end
    end
    if (!dumped && m_valid[d] && ordy) m_valid[d] = 1'b0;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < ND; d++) begin
        model_clear_lanes(d);
        m_valid[d] = 1'b0;
        m_err[d]   = 1'b0;
        m_ch[d]    = 0;
        m_data[d]  = 0;
        m_oovf[d]  = 1'b0;
      end
    end else begin
      model_step(0, clr_a, bus_a.in_valid, int'(bus_a.in_ch), longint'(bus_a.in_data), bus_a.out_ready);
      model_step(1, clr_b, bus_b.in_valid, int'(bus_b.in_ch), longint'(bus_b.in_data), bus_b.out_ready);
    end
  end

  task automatic compare(input int d, input bit clr, input bit ordy, input logic irdy,
                         input logic ov, input logic [1:0] och, input logic signed [21:0] od,
                         input logic oovf, input logic err);
    chk("in_ready", d, irdy, (!clr && (!m_valid[d] || ordy)) ? 1 : 0);
    chk("out_valid", d, ov, m_valid[d] ? 1 : 0);
    chk("err_ch", d, err, m_err[d] ? 1 : 0);
    if (m_valid[d]) begin
      chk("out_ch", d, och, m_ch[d]);
      chk("out_data", d, od, m_data[d]);
      chk("out_ovf", d, oovf, m_oovf[d] ? 1 : 0);
    end
    if (ov === 1'b1 && ordy) log_q[d].push_back('{int'(och), longint'(od), oovf});
  endtask

  always @(negedge clk) begin
    if (run_chk && !reset) begin
      compare(0, clr_a, bus_a.out_ready, bus_a.in_ready, bus_a.out_valid, bus_a.out_ch,
              bus_a.out_data, bus_a.out_ovf, bus_a.err_ch);
      compare(1, clr_b, bus_b.out_ready, bus_b.in_ready, bus_b.out_valid, bus_b.out_ch,
              bus_b.out_data, bus_b.out_ovf, bus_b.err_ch);
    end
  end

  task automatic send(input int d, input int ch, input int data);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    if (d == 0) begin
      bus_a.in_valid = 1'b1; bus_a.in_ch = 2'(ch); bus_a.in_data = 16'(data);
    end else begin
      bus_b.in_valid = 1'b1; bus_b.in_ch = 2'(ch); bus_b.in_data = 16'(data);
    end
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = (d == 0) ? (bus_a.in_ready === 1'b1) : (bus_b.in_ready === 1'b1);
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout dut%0d actual in_ready=0 for %0d cycles required 1", d, n);
    end
    if (d == 0) bus_a.in_valid = 1'b0;
    else        bus_b.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_dump(input int d, input string nm, input int ch, input longint data, input bit ovf);
    dump_t x;
    if (log_q[d].size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s dut%0d actual no dump required ch%0d data %0d", nm, d, ch, data);
    end else begin
      x = log_q[d].pop_front();
      chk({nm, "_ch"}, d, x.ch, ch);
      chk({nm, "_data"}, d, x.data, data);
      chk({nm, "_ovf"}, d, x.ovf, ovf ? 1 : 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1);
  end

  initial begin
    longint exp_b;
    reset = 1'b1;
    clr_a = 1'b0;
    clr_b = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_ch = '0; bus_a.in_data = '0; bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.in_ch = '0; bus_b.in_data = '0; bus_b.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", 0, bus_a.out_valid, 0);
    chk("rst_out_ch", 0, bus_a.out_ch, 0);
    chk("rst_out_data", 0, bus_a.out_data, 0);
    chk("rst_out_ovf", 0, bus_a.out_ovf, 0);
    chk("rst_err_ch", 0, bus_a.err_ch, 0);
    chk("rst_out_valid", 1, bus_b.out_valid, 0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    run_chk = 1'b1;

    // 8 x +3 on ch1: dump visible right after the 8th product's edge.
    for (int i = 0; i < 8; i++) send(0, 1, 3);
    chk("t1_latency", 0, bus_a.out_valid, 1);
    idle(3);
    expect_dump(0, "t1", 1, 24, 1'b0);

    // Interleaved ch0 (+5) and ch2 (-7).
    for (int i = 0; i < 8; i++) begin
      send(0, 0, 5);
      send(0, 2, -7);
    end
    idle(3);
    expect_dump(0, "t2a", 0, 40, 1'b0);
    expect_dump(0, "t2b", 2, -56, 1'b0);

    // Back-pressure: dump stalls the input for 10 cycles, nothing lost.
    bus_a.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(0, 1, 1);
    bus_a.in_valid = 1'b1; bus_a.in_ch = 2'd1; bus_a.in_data = 16'sd4;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_in_ready_low", 0, bus_a.in_ready, 0);
      chk("t3_hold_valid", 0, bus_a.out_valid, 1);
      chk("t3_hold_data", 0, bus_a.out_data, 8);
      @(posedge clk);
      #1;
    end
    bus_a.out_ready = 1'b1;
    send(0, 1, 4);
    for (int i = 0; i < 7; i++) send(0, 1, 1);
    idle(3);
    expect_dump(0, "t3a", 1, 8, 1'b0);
    expect_dump(0, "t3b", 1, 11, 1'b0);

    // clear discards a partial window on ch3.
    for (int i = 0; i < 4; i++) send(0, 3, 2);
    clr_a = 1'b1;
    @(negedge clk);
    chk("t5_in_ready_clear", 0, bus_a.in_ready, 0);
    @(posedge clk);
    #1;
    clr_a = 1'b0;
    for (int i = 0; i < 8; i++) send(0, 3, 1);
    idle(3);
    expect_dump(0, "t5", 3, 8, 1'b0);
    chk("a_no_extra_dumps", 0, log_q[0].size(), 0);

    // Out-of-range channel mid-window, then overflow over 72 products.
    for (int i = 0; i < 3; i++) send(1, 0, 32767);
    send(1, 3, 1000);
    chk("t6_err_pulse", 1, bus_b.err_ch, 1);
    chk("t6_no_dump", 1, bus_b.out_valid, 0);
    idle(1);
    chk("t6_err_clear", 1, bus_b.err_ch, 0);
    for (int i = 0; i < 69; i++) send(1, 0, 32767);
`ifdef MAC_ACC_SAT_EN
    exp_b = 2097151;
`else
    exp_b = -1835080;
`endif
    idle(3);
    expect_dump(1, "t4", 0, exp_b, 1'b1);
    chk("b_no_extra_dumps", 1, log_q[1].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
